// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - shared types and constants for the serial shift-register feeder
package shreg_pkg;

  // Feeder control states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Depth of one downstream serial-in shift-register cell
  localparam int SHREG_CELL_BITS = 8;

  // Word length limits; the upper bound is a chain of eight cells
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 8 * SHREG_CELL_BITS;

endpackage

// File: rtl/shreg_bitcnt.sv
// rtl/shreg_bitcnt.sv - bit counter with clear, enable and terminal-count flag
module shreg_bitcnt
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  // Count enabled clocks 0..WIDTH-1; clear wins over enable, wrap at terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/shreg_piso_feeder.sv
// rtl/shreg_piso_feeder.sv - parallel-to-serial feeder for an enable-gated shift-register chain
module shreg_piso_feeder
  import shreg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VALID,
  output logic             READY,
  input  logic             HOLD,
  output logic             SD,
  output logic             SE,
  output logic             DONE,
  output logic             BUSY
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("shreg_piso_feeder: WIDTH outside the supported chain depth");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic             out_bit;
  logic             tc;
  logic             accept;
  logic             last_shift;

  // Shift toward the output end with zero fill; output end chosen by LSB_FIRST
  always_comb begin
    if (LSB_FIRST) begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
      out_bit      = sreg[0];
    end else begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
      out_bit      = sreg[WIDTH-1];
    end
  end

  // State register
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/serial outputs; READY never looks at VALID
  always_comb begin
    state_nxt = state;
    READY     = 1'b0;
    SE        = 1'b0;
    BUSY      = 1'b0;
    SD        = 1'b0;
    case (state)
      ST_IDLE: begin
        READY = 1'b1;
        if (VALID) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        BUSY  = 1'b1;
        SE    = !HOLD;
        SD    = out_bit;
        READY = tc && !HOLD;
        if (READY && !VALID) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept     = VALID && READY;
  assign last_shift = SE && tc;

  // Load on accept, otherwise shift one bit on every enabled SHIFT clock
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      sreg <= '0;
    end else if (accept) begin
      sreg <= DIN;
    end else if (SE) begin
      sreg <= sreg_shifted;
    end
  end

  // One-cycle completion pulse after the final shift edge of each word
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      DONE <= 1'b0;
    end else begin
      DONE <= last_shift;
    end
  end

  shreg_bitcnt #(
    .WIDTH(WIDTH)
  ) u_bitcnt (
    .clk(C),
    .rst(R),
    .clr(accept),
    .en (SE),
    .tc (tc)
  );

endmodule

// File: tb/tb_shreg_piso_feeder.sv
// tb/tb_shreg_piso_feeder.sv - randomized self-checking bench for shreg_piso_feeder
module tb_shreg_piso_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       valid;
  logic       hold;

  logic ready0, sd0, se0, done0, busy0;
  logic ready1, sd1, se1, done1, busy1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: pending bits of the word in flight, in emission order
  bit q_msb[$];
  bit q_lsb[$];
  bit m_done;

  int cyc = 0;
  int acc_cyc;
  int done_cyc;
  int se_seen;
  int done_seen;
  int ready_seen;

  always #5 clk = ~clk;

  shreg_piso_feeder #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
    .C(clk), .R(rst), .DIN(din), .VALID(valid), .READY(ready0), .HOLD(hold),
    .SD(sd0), .SE(se0), .DONE(done0), .BUSY(busy0)
  );

  shreg_piso_feeder #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_lsb (
    .C(clk), .R(rst), .DIN(din), .VALID(valid), .READY(ready1), .HOLD(hold),
    .SD(sd1), .SE(se1), .DONE(done1), .BUSY(busy1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    se_seen    = 0;
    done_seen  = 0;
    ready_seen = 0;
    done_cyc   = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready_m"}, int'(ready0), 1);
    chk({tag, "_ready_l"}, int'(ready1), 1);
    chk({tag, "_se"},      int'(se0) + int'(se1), 0);
    chk({tag, "_sd"},      int'(sd0) + int'(sd1), 0);
    chk({tag, "_busy"},    int'(busy0) + int'(busy1), 0);
    chk({tag, "_done"},    int'(done0) + int'(done1), 0);
  endtask

  // Assert reset away from a clock edge, check outputs before any edge, hold over one edge
  task automatic do_reset();
    valid = 1'b0;
    hold  = 1'b0;
    rst   = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    q_msb.delete();
    q_lsb.delete();
    m_done = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs mid-cycle, then advance the model at the edge
  task automatic step(input bit v, input logic [7:0] d, input bit h);
    int n;
    bit rdy, se_e, done_next;
    cyc++;
    valid = v;
    din   = d;
    hold  = h;
    @(negedge clk);
    n    = q_msb.size();
    rdy  = (n == 0) || (n == 1 && !h);
    se_e = (n > 0) && !h;
    chk("ready_m", int'(ready0), int'(rdy));
    chk("ready_l", int'(ready1), int'(rdy));
    chk("se_m",    int'(se0),    int'(se_e));
    chk("se_l",    int'(se1),    int'(se_e));
    chk("busy_m",  int'(busy0),  int'(n > 0));
    chk("busy_l",  int'(busy1),  int'(n > 0));
    chk("done_m",  int'(done0),  int'(m_done));
    chk("done_l",  int'(done1),  int'(m_done));
    chk("sd_m",    int'(sd0),    (n > 0) ? int'(q_msb[0]) : 0);
    chk("sd_l",    int'(sd1),    (n > 0) ? int'(q_lsb[0]) : 0);
    if (se0)    se_seen++;
    if (ready0) ready_seen++;
    if (done0) begin
      done_seen++;
      done_cyc = cyc;
    end
    @(posedge clk);
    done_next = 1'b0;
    if (se_e) begin
      void'(q_msb.pop_front());
      void'(q_lsb.pop_front());
      if (q_msb.size() == 0) done_next = 1'b1;
    end
    if (v && rdy) begin
      for (int i = 7; i >= 0; i--) q_msb.push_back(d[i]);
      for (int i = 0; i <= 7; i++) q_lsb.push_back(d[i]);
    end
    m_done = done_next;
    #1;
  endtask

  // Idle the inputs until the model has no word and no pending DONE
  task automatic drain();
    int k;
    k = 0;
    while (q_msb.size() > 0 || m_done) begin
      step(1'b0, 8'($urandom), 1'b0);
      k++;
      if (k > 40) begin
        chk("drain_timeout", 1, 0);
        break;
      end
    end
    step(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    din   = 8'h00;
    valid = 1'b0;
    hold  = 1'b0;
    do_reset();

    // Single word A5, no stalls
    clear_stats();
    step(1'b1, 8'hA5, 1'b0);
    acc_cyc = cyc;
    drain();
    chk("a5_se_cycles", se_seen, 8);
    chk("a5_done_pulses", done_seen, 1);
    chk("a5_done_latency", done_cyc - acc_cyc, 9);

    // Single word 01 (LSB-first instance emits the 1 first)
    clear_stats();
    step(1'b1, 8'h01, 1'b0);
    drain();
    chk("w01_done_pulses", done_seen, 1);

    // Back-to-back FF then 00 with VALID held high
    clear_stats();
    step(1'b1, 8'hFF, 1'b0);
    repeat (8) step(1'b1, 8'h00, 1'b0);
    chk("b2b_ready_cycles", ready_seen, 2);
    drain();
    chk("b2b_se_cycles", se_seen, 16);
    chk("b2b_done_pulses", done_seen, 2);

    // Stall for 3 cycles after bit 3 of C3
    clear_stats();
    step(1'b1, 8'hC3, 1'b0);
    acc_cyc = cyc;
    repeat (3) step(1'b0, 8'h00, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    drain();
    chk("hold_se_cycles", se_seen, 8);
    chk("hold_done_latency", done_cyc - acc_cyc, 12);

    // Reset during bit 5, then a fresh word
    clear_stats();
    step(1'b1, 8'h96, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0);
    do_reset();
    repeat (2) step(1'b0, 8'h00, 1'b0);
    chk("rst_no_done", done_seen, 0);
    clear_stats();
    step(1'b1, 8'h6B, 1'b0);
    drain();
    chk("post_rst_done_pulses", done_seen, 1);

    // VALID pulse with 3C mid-word must be ignored
    clear_stats();
    step(1'b1, 8'h5A, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    drain();
    chk("ignore_se_cycles", se_seen, 8);
    chk("ignore_done_pulses", done_seen, 1);

    // Random traffic with random stalls
    repeat (400) step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
